fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues 16-bit reads with a mandatory idle cycle
// between them and buffers up to two {pc, instr} pairs for the decoder.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] addr_o,
   output logic        re_o,
   input  logic        needWait_i,
   input  logic [15:0] data_i,
   input  logic        redirect_i,
   input  logic [15:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [15:0] instr_o,
   output logic [15:0] instr_pc_o,
   input  logic        instr_ready_i
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      GAP   = 2'd1,
      STALL = 2'd2
   } fetch_state_t;

   fetch_state_t fsm_state, state_d;

   logic [15:0] pc_q, pc_d;
   logic [15:0] addr_q;
   logic [1:0]  count_q, count_d;
   logic [1:0]  count_after_pop;
   logic [15:0] e0_pc_q, e0_ins_q, e1_pc_q, e1_ins_q;
   logic [15:0] e0_pc_d, e0_ins_d, e1_pc_d, e1_ins_d;
   logic        complete;
   logic        pop;

   // Consumer handshake: an entry transfers on a rising edge where
   // instr_valid_o and instr_ready_i are both high; valid never depends on ready.
   assign re_o          = (fsm_state == FETCH);
   assign addr_o        = re_o ? pc_q : addr_q;
   assign instr_valid_o = (count_q != 2'd0);
   assign instr_o       = e0_ins_q;
   assign instr_pc_o    = e0_pc_q;

   assign complete        = re_o && !needWait_i;
   assign pop             = instr_valid_o && instr_ready_i;
   assign count_after_pop = count_q - {1'b0, pop};

   always_comb begin
      state_d  = fsm_state;
      pc_d     = pc_q;
      count_d  = count_after_pop + {1'b0, complete};
      e0_pc_d  = e0_pc_q;
      e0_ins_d = e0_ins_q;
      e1_pc_d  = e1_pc_q;
      e1_ins_d = e1_ins_q;

      case (fsm_state)
         FETCH: begin
            if (complete) begin
               state_d = GAP;
               pc_d    = pc_q + 16'd2;
            end
         end
         GAP, STALL: state_d = (count_after_pop < 2'd2) ? FETCH : STALL;
         default:    state_d = GAP;
      endcase

      // Head is always entry 0: a pop shifts, then a push lands in the first free slot.
      if (pop) begin
         e0_pc_d  = e1_pc_q;
         e0_ins_d = e1_ins_q;
      end
      if (complete) begin
         if (count_after_pop == 2'd0) begin
            e0_pc_d  = pc_q;
            e0_ins_d = data_i;
         end else begin
            e1_pc_d  = pc_q;
            e1_ins_d = data_i;
         end
      end

      if (redirect_i) begin
         state_d = GAP;
         pc_d    = redirect_pc_i & 16'hFFFE;
         count_d = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_state <= GAP;
         pc_q      <= RESET_PC & 16'hFFFE;
         addr_q    <= 16'h0000;
         count_q   <= 2'd0;
         e0_pc_q   <= 16'h0000;
         e0_ins_q  <= 16'h0000;
         e1_pc_q   <= 16'h0000;
         e1_ins_q  <= 16'h0000;
      end else begin
         fsm_state <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_o;
         count_q   <= count_d;
         e0_pc_q   <= e0_pc_d;
         e0_ins_q  <= e0_ins_d;
         e1_pc_q   <= e1_pc_d;
         e1_ins_q  <= e1_ins_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all compared
// against a queue-based reference model and a wait-state memory responder.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr_o;
   logic        re_o;
   logic        needWait_i;
   logic [15:0] data_i;
   logic        redirect_i;
   logic [15:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [15:0] instr_o;
   logic [15:0] instr_pc_o;
   logic        instr_ready_i;

   logic [15:0] w_addr, w_instr, w_pc;
   logic        w_re, w_valid;
   logic        w_need = 1'b0;
   logic        w_redir = 1'b0;
   logic        w_ready = 1'b1;
   logic [15:0] w_data = 16'hC0DE;
   logic [15:0] w_rpc = 16'h0000;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .addr_o(addr_o), .re_o(re_o),
      .needWait_i(needWait_i), .data_i(data_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .instr_valid_o(instr_valid_o),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i)
   );

   fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .addr_o(w_addr), .re_o(w_re),
      .needWait_i(w_need), .data_i(w_data), .redirect_i(w_redir),
      .redirect_pc_i(w_rpc), .instr_valid_o(w_valid),
      .instr_o(w_instr), .instr_pc_o(w_pc), .instr_ready_i(w_ready)
   );

   // reference model: next fetch pc, whether a read is outstanding, buffered entries
   logic [15:0] m_pc, m_addr;
   bit          m_reading;
   logic [31:0] m_q[$];

   // memory responder state
   bit in_read, prev_complete;
   int cur_wait, wait_cnt, wait_mode, b2b;

   int n_vec, n_fail;
   logic [15:0] w_addrs[$], w_pcs[$];
   logic [15:0] a_addrs[$], a_pcs[$], g_addrs[$];
   int          a_cyc[$];
   int          nreads;
   bit          prev_re;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0] ^ 8'h3C, a[15:8] + 8'h71};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pc      = 16'h0000;
      m_addr    = 16'h0000;
      m_reading = 1'b0;
      m_q.delete();
   endtask

   task automatic check_outputs();
      logic [15:0] ea;
      ea     = m_reading ? m_pc : m_addr;
      m_addr = ea;
      chk("re_o", {15'd0, re_o}, {15'd0, m_reading});
      chk("addr_o", addr_o, ea);
      chk("instr_valid_o", {15'd0, instr_valid_o}, (m_q.size() > 0) ? 16'd1 : 16'd0);
      if (m_q.size() > 0) begin
         chk("instr_o", instr_o, m_q[0][15:0]);
         chk("instr_pc_o", instr_pc_o, m_q[0][31:16]);
      end
   endtask

   // One clock: check outputs, drive inputs, advance the model, cross the edge.
   task automatic step(input bit rst_v, input bit rdy, input bit redir, input logic [15:0] rpc);
      bit          need;
      logic [15:0] d;
      check_outputs();
      if (w_re === 1'b1 && w_addrs.size() < 2) w_addrs.push_back(w_addr);
      if (w_valid === 1'b1 && w_pcs.size() < 2) w_pcs.push_back(w_pc);

      if (re_o !== 1'b1) in_read = 1'b0;
      else if (!in_read) begin
         in_read  = 1'b1;
         wait_cnt = 0;
         cur_wait = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
      end
      need = in_read ? (wait_cnt < cur_wait) : 1'($urandom_range(0, 1));
      d    = (in_read && !need) ? mem_word(addr_o) : 16'($urandom);
      if (prev_complete && re_o === 1'b1) b2b++;
      prev_complete = in_read && !need;
      if (in_read && need) wait_cnt++;

      rst_n         = rst_v;
      needWait_i    = need;
      data_i        = d;
      instr_ready_i = rdy;
      redirect_i    = redir;
      redirect_pc_i = rpc;

      if (!rst_v) m_reset();
      else if (redir) begin
         m_q.delete();
         m_pc      = rpc & 16'hFFFE;
         m_reading = 1'b0;
      end else begin
         if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
         if (m_reading) begin
            if (!need) begin
               m_q.push_back({m_pc, mem_word(m_pc)});
               m_pc      = m_pc + 16'd2;
               m_reading = 1'b0;
            end
         end else m_reading = (m_q.size() < 2);
      end

      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_vec = 0; n_fail = 0; b2b = 0;
      in_read = 1'b0; prev_complete = 1'b0; wait_cnt = 0; cur_wait = 0; wait_mode = 0;
      rst_n = 1'b0; needWait_i = 1'b0; data_i = 16'h0000;
      redirect_i = 1'b0; redirect_pc_i = 16'h0000; instr_ready_i = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);

      // reset values
      step(0, 0, 0, 0);
      chk("rst_re", {15'd0, re_o}, 16'd0);
      chk("rst_valid", {15'd0, instr_valid_o}, 16'd0);
      chk("rst_addr", addr_o, 16'h0000);
      chk("rst_instr", instr_o, 16'h0000);
      chk("rst_instr_pc", instr_pc_o, 16'h0000);

      // one wait per read, consumer always ready
      wait_mode = 1;
      prev_re   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (re_o === 1'b1 && !prev_re) begin
            a_addrs.push_back(addr_o);
            a_cyc.push_back(i);
         end
         if (instr_valid_o === 1'b1) a_pcs.push_back(instr_pc_o);
         prev_re = (re_o === 1'b1);
         step(1, 1, 0, 0);
      end
      for (int i = 0; i < 3; i++) begin
         chk("A_read_addr", (a_addrs.size() > i) ? a_addrs[i] : 16'hDEAD, 16'(2 * i));
         chk("A_out_pc", (a_pcs.size() > i) ? a_pcs[i] : 16'hDEAD, 16'(2 * i));
      end
      chk("A_period01", (a_cyc.size() > 1) ? 16'(a_cyc[1] - a_cyc[0]) : 16'hDEAD, 16'd3);
      chk("A_period12", (a_cyc.size() > 2) ? 16'(a_cyc[2] - a_cyc[1]) : 16'hDEAD, 16'd3);
      chk("W_read0", (w_addrs.size() > 0) ? w_addrs[0] : 16'hDEAD, 16'hFFFE);
      chk("W_read1", (w_addrs.size() > 1) ? w_addrs[1] : 16'hDEAD, 16'h0000);
      chk("W_pc0", (w_pcs.size() > 0) ? w_pcs[0] : 16'hDEAD, 16'hFFFE);
      chk("W_pc1", (w_pcs.size() > 1) ? w_pcs[1] : 16'hDEAD, 16'h0000);

      // backpressure: 20 cycles without ready
      wait_mode = 0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      nreads  = 0;
      prev_re = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (re_o === 1'b1 && !prev_re) nreads++;
         prev_re = (re_o === 1'b1);
         step(1, 0, 0, 0);
      end
      chk("B_nreads", 16'(nreads), 16'd2);
      chk("B_stall_re", {15'd0, re_o}, 16'd0);
      chk("B_stall_valid", {15'd0, instr_valid_o}, 16'd1);
      chk("B_head_pc", instr_pc_o, 16'h0000);
      step(1, 1, 0, 0);
      chk("B_resume_re", {15'd0, re_o}, 16'd1);
      chk("B_resume_addr", addr_o, 16'h0004);
      repeat (4) step(1, 0, 0, 0);

      // redirect while the memory is still waiting
      wait_mode = 3;
      step(0, 1, 0, 0);
      for (int i = 0; i < 10 && re_o !== 1'b1; i++) step(1, 1, 0, 0);
      chk("C_read_seen", {15'd0, re_o}, 16'd1);
      step(1, 1, 1, 16'h0101);
      chk("C_redir_re", {15'd0, re_o}, 16'd0);
      chk("C_redir_valid", {15'd0, instr_valid_o}, 16'd0);
      for (int i = 0; i < 20 && re_o !== 1'b1; i++) step(1, 1, 0, 0);
      chk("C_new_addr", addr_o, 16'h0100);
      for (int i = 0; i < 30 && instr_valid_o !== 1'b1; i++) step(1, 1, 0, 0);
      chk("C_first_valid", {15'd0, instr_valid_o}, 16'd1);
      chk("C_first_pc", instr_pc_o, 16'h0100);

      // redirect on the completing cycle with a pop pending
      wait_mode = 0;
      step(0, 0, 0, 0);
      for (int i = 0; i < 20 && !(re_o === 1'b1 && instr_valid_o === 1'b1); i++) step(1, 0, 0, 0);
      chk("D_setup", {14'd0, re_o, instr_valid_o}, 16'd3);
      chk("D_setup_addr", addr_o, 16'h0002);
      step(1, 1, 1, 16'h0200);
      chk("D_redir_valid", {15'd0, instr_valid_o}, 16'd0);
      chk("D_redir_re", {15'd0, re_o}, 16'd0);
      for (int i = 0; i < 10 && re_o !== 1'b1; i++) step(1, 1, 0, 0);
      chk("D_new_addr", addr_o, 16'h0200);
      for (int i = 0; i < 10 && instr_valid_o !== 1'b1; i++) step(1, 1, 0, 0);
      chk("D_first_pc", instr_pc_o, 16'h0200);
      chk("D_first_instr", instr_o, mem_word(16'h0200));

      // pc wrap through a redirect near the top of memory
      step(1, 1, 1, 16'hFFFC);
      for (int i = 0; i < 12; i++) begin
         if (re_o === 1'b1) g_addrs.push_back(addr_o);
         step(1, 1, 0, 0);
      end
      chk("G_addr0", (g_addrs.size() > 0) ? g_addrs[0] : 16'hDEAD, 16'hFFFC);
      chk("G_addr1", (g_addrs.size() > 1) ? g_addrs[1] : 16'hDEAD, 16'hFFFE);
      chk("G_addr2", (g_addrs.size() > 2) ? g_addrs[2] : 16'hDEAD, 16'h0000);

      // reset in the middle of a waiting read
      wait_mode = 3;
      for (int i = 0; i < 10 && re_o !== 1'b1; i++) step(1, 1, 0, 0);
      chk("E_read_seen", {15'd0, re_o}, 16'd1);
      step(0, 1, 0, 0);
      chk("E_rst_re", {15'd0, re_o}, 16'd0);
      chk("E_rst_valid", {15'd0, instr_valid_o}, 16'd0);
      chk("E_rst_instr", instr_o, 16'h0000);
      step(1, 1, 0, 0);
      chk("E_first_re", {15'd0, re_o}, 16'd1);
      chk("E_first_addr", addr_o, 16'h0000);

      // random traffic
      wait_mode = -1;
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 99) < 4), 16'($urandom));
      end

      chk("no_back_to_back", 16'(b2b), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
